// File: rtl/mem_port_arbiter_if.sv
// Bundle for the two requesters (IF fetch, EX load/store), the shared memory port
// and the arbiter status outputs.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          ex_req;
  logic          ex_we;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata;
  logic          ex_ack;
  logic [DW-1:0] ex_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, ex_ack, ex_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  // Requester / memory side.
  modport master (
    output if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, ex_ack, ex_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and EX load/store. EX has priority;
// a starvation counter forces an IF grant after STARVE_MAX consecutive EX wins.
module mem_port_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic          clk,
  input logic          rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] StarveLimit = CW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ex_rdata_q, ex_rdata_d;
  logic [CW-1:0] starve_q, starve_d;

  logic if_wins;

  // IF only beats a concurrent EX request once EX has won STARVE_MAX times in a row.
  assign if_wins = bus.if_req &&
                   (!bus.ex_req || ((STARVE_MAX != 0) && (starve_q == StarveLimit)));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ex_rdata_d  = ex_rdata_q;
    starve_d    = starve_q;

    unique case (state_q)
      StIdle: begin
        if (bus.if_req || bus.ex_req) begin
          state_d   = StAccess;
          mem_req_d = 1'b1;
          if (if_wins) begin
            owner_d     = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = 1'b1;
            mem_we_d    = bus.ex_we;
            mem_addr_d  = bus.ex_addr;
            mem_wdata_d = bus.ex_wdata;
            if (!bus.if_req) begin
              starve_d = '0;
            end else if (starve_q != StarveLimit) begin
              starve_d = starve_q + CW'(1);
            end
          end
        end
      end
      StAccess: begin
        if (bus.mem_ack) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!owner_q) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!mem_we_q) begin
            ex_rdata_d = bus.mem_rdata;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ex_rdata_q  <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ex_rdata_q  <= ex_rdata_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ex_rdata  = ex_rdata_q;
  assign bus.if_ack    = (state_q == StResp) && !owner_q;
  assign bus.ex_ack    = (state_q == StResp) && owner_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.owner     = owner_q;

endmodule
